// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: request/address in,
// one-hot grant and tagged palette-index response out.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  modport master (output req, req_addr, input gnt, rsp_valid, rsp_id, rsp_data);
  modport slave  (input req, req_addr, output gnt, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous-read sprite ROM among NUM_REQ
// sprite drawing units. One grant per cycle, address registered into the ROM,
// {valid,id} tag pipeline returns the palette index to its owner in grant order.
// Optional feature: define SPRITE_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority with requester 0 (player jet) highest.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  sprite_rom_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [DATA_W-1:0]     rom_q,
  output logic [15:0]           conflict_cnt,
  input  logic                  cnt_clear
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         gnt;
  logic [ID_W-1:0]            gnt_id;
  logic                       gnt_any;
  logic [ID_W-1:0]            start_id;
  int                         idx;
  logic [ADDR_W-1:0]          gnt_addr;
  logic                       conflict;

  logic [ROM_LAT:0]           vld_pipe;
  logic [ROM_LAT:0][ID_W-1:0] id_pipe;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [DATA_W-1:0]          rsp_data;

`ifdef SPRITE_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  assign start_id = rr_ptr;
`else
  assign start_id = '0;
`endif

  // Search upward from start_id with wrap; first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && bus.req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  assign gnt_addr  = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign conflict  = |(bus.req & (bus.req - 1'b1));

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;

`ifdef SPRITE_ARB_RR_EN
  // Pointer moves one past the winner; idle cycles leave it alone.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
  end
`endif

  // Launch the granted address and push its tag into the pipeline.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
    end else begin
      if (gnt_any) rom_address <= gnt_addr;
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], gnt_any};
      id_pipe  <= {id_pipe[ROM_LAT-1:0], gnt_id};
    end
  end

  // Pipeline tail lines up with rom_q; data and id hold between responses.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_pipe[ROM_LAT];
      if (vld_pipe[ROM_LAT]) begin
        rsp_id   <= id_pipe[ROM_LAT];
        rsp_data <= rom_q;
      end
    end
  end

  // Saturating contention counter; clear beats increment.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      conflict_cnt <= '0;
    else if (cnt_clear)
      conflict_cnt <= '0;
    else if (conflict && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a ROM_LAT=1 instance and a ROM_LAT=2
// instance, each fed by a ROM model that returns address[3:0].
module tb_sprite_rom_arbiter;
  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        cnt_clear2 = 1'b0;
  logic [10:0] rom_address, rom_address2;
  logic [3:0]  rom_q = '0, rom_q2 = '0, rom_s2 = '0;
  logic [15:0] conflict_cnt, conflict_cnt2;
  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4)) b();
  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4)) b2();

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4), .ROM_LAT(1)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(b), .rom_address(rom_address),
    .rom_q(rom_q), .conflict_cnt(conflict_cnt), .cnt_clear(cnt_clear));

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4), .ROM_LAT(2)) dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(b2), .rom_address(rom_address2),
    .rom_q(rom_q2), .conflict_cnt(conflict_cnt2), .cnt_clear(cnt_clear2));

  always #5 vga_clk = ~vga_clk;

  // ROM models: 1- and 2-cycle synchronous reads returning address[3:0].
  always @(posedge vga_clk) begin
    rom_q  <= rom_address[3:0];
    rom_s2 <= rom_address2[3:0];
    rom_q2 <= rom_s2;
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b.req = 4'($urandom);
    for (int i = 0; i < 4; i++) b.req_addr[i*11 +: 11] = 11'($urandom);
    repeat (3) tick();
    checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", b.rsp_valid); end
    checks++; if (rom_address !== 11'd0) begin errors++; $display("FAIL reset_rom_address got %0d want 0", rom_address); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conflict_cnt got %0d want 0", conflict_cnt); end
    checks++; if (b.rsp_id !== 2'd0 || b.rsp_data !== 4'd0) begin errors++; $display("FAIL reset_rsp got id %0d data %h want 0 0", b.rsp_id, b.rsp_data); end
    b.req = 4'b0110; #1;
    checks++; if (b.gnt !== 4'b0010) begin errors++; $display("FAIL reset_gnt got %b want 0010", b.gnt); end
    b.req = 4'b0000; b2.req = 4'b0000;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle cycle %0d rsp_valid got %b want 0", i, b.rsp_valid); end
    end
  endtask

  task automatic test_single();
    b.req_addr[2*11 +: 11] = 11'd123;
    b.req = 4'b0100; #1;
    checks++; if (b.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", b.gnt); end
    tick(); b.req = 4'b0000;
    checks++; if (rom_address !== 11'd123) begin errors++; $display("FAIL single_rom_address got %0d want 123", rom_address); end
    for (int c = 1; c < 3; c++) begin
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early cycle %0d rsp_valid got %b want 0", c, b.rsp_valid); end
      tick();
    end
    checks++; if (b.rsp_valid !== 1'b1 || b.rsp_id !== 2'd2 || b.rsp_data !== 4'hB) begin
      errors++; $display("FAIL single_rsp got v%b id %0d data %h want v1 id 2 data b", b.rsp_valid, b.rsp_id, b.rsp_data); end
    tick();
    checks++; if (b.rsp_valid !== 1'b0 || b.rsp_data !== 4'hB) begin
      errors++; $display("FAIL single_hold got v%b data %h want v0 data b", b.rsp_valid, b.rsp_data); end
  endtask

  task automatic test_back_to_back();
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    for (int i = 0; i < 4; i++) b.req_addr[i*11 +: 11] = 11'h200 | 11'(4 + i);
    b.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c > 0 && c <= 4) b.req[c-1] = 1'b0;
      #1;
      if (c < 4) begin
        checks++; if (b.gnt !== 4'(1 << c)) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, b.gnt, 4'(1 << c)); end
      end
      if (c >= 3 && c <= 6) begin
        checks++; if (b.rsp_valid !== 1'b1 || b.rsp_id !== 2'(c-3) || b.rsp_data !== 4'(c+1)) begin
          errors++; $display("FAIL b2b_rsp cycle %0d got v%b id %0d data %h want v1 id %0d data %h",
                             c, b.rsp_valid, b.rsp_id, b.rsp_data, c-3, 4'(c+1)); end
      end
      if (c == 7) begin
        checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got v%b want 0", b.rsp_valid); end
      end
      tick();
    end
    checks++; if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL b2b_conflict_cnt got %0d want 3", conflict_cnt); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    b.req = 4'b1000; #1;
    checks++; if (b.gnt !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got %b want 1000", b.gnt); end
    tick(); b.req = 4'b1001; #1;
    checks++; if (b.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got %b want 0001", b.gnt); end
    tick(); b.req = 4'b1000; #1;
    checks++; if (b.gnt !== 4'b1000) begin errors++; $display("FAIL wrap_then3 got %b want 1000", b.gnt); end
    tick(); b.req = 4'b0001; #1;
    tick(); b.req = 4'b1001; #1;
`ifdef SPRITE_ARB_RR_EN
    exp = 4'b1000;
`else
    exp = 4'b0001;
`endif
    checks++; if (b.gnt !== exp) begin errors++; $display("FAIL policy_after0 got %b want %b", b.gnt, exp); end
    tick(); b.req = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic test_counter();
    b.req = 4'b0011; cnt_clear = 1'b1;
    tick(); cnt_clear = 1'b0;
    repeat (10) tick();
    checks++; if (conflict_cnt !== 16'd10) begin errors++; $display("FAIL cnt_10 got %0d want 10", conflict_cnt); end
    repeat (70000) tick();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h want ffff", conflict_cnt); end
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", conflict_cnt); end
    tick();
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL cnt_after_clear got %0d want 1", conflict_cnt); end
    b.req = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic test_midflight_reset();
    b.req_addr[2*11 +: 11] = 11'd123;
    b.req = 4'b0100;
    tick(); b.req = 4'b0000; reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    checks++; if (rom_address !== 11'd0) begin errors++; $display("FAIL midreset_rom_address got %0d want 0", rom_address); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp cycle %0d got v%b want 0", i, b.rsp_valid); end
      tick();
    end
  endtask

  task automatic test_lat2();
    b2.req_addr = '0;
    b2.req_addr[2*11 +: 11] = 11'd123;
    b2.req = 4'b0100; #1;
    checks++; if (b2.gnt !== 4'b0100) begin errors++; $display("FAIL lat2_gnt got %b want 0100", b2.gnt); end
    tick(); b2.req = 4'b0000;
    for (int c = 1; c < 4; c++) begin
      checks++; if (b2.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat2_early cycle %0d got v%b want 0", c, b2.rsp_valid); end
      tick();
    end
    checks++; if (b2.rsp_valid !== 1'b1 || b2.rsp_id !== 2'd2 || b2.rsp_data !== 4'hB) begin
      errors++; $display("FAIL lat2_rsp got v%b id %0d data %h want v1 id 2 data b", b2.rsp_valid, b2.rsp_id, b2.rsp_data); end
    tick();
    checks++; if (b2.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat2_single got v%b want 0", b2.rsp_valid); end
  endtask

  initial begin
    b.req = '0; b.req_addr = '0; b2.req = '0; b2.req_addr = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_counter();
    test_midflight_reset();
    test_lat2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
